// File: rtl/keypad_encoder_if.sv
// keypad_encoder_if: groups the keypad pins and the encoder-to-FSM key outputs.
//   row_n    : keypad rows, active low (pins -> encoder)
//   col_n    : keypad column drive, one bit low (encoder -> pins)
//   tecla    : encoded key code (encoder -> calculator FSM)
//   ready    : key-code strobe (encoder -> calculator FSM)
//   key_down : key held between confirmed press and confirmed release
interface keypad_encoder_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] tecla;
  logic       ready;
  logic       key_down;

  // Encoder side.
  modport master (
    input  row_n,
    output col_n,
    output tecla,
    output ready,
    output key_down
  );

  // Keypad / consumer side.
  modport slave (
    output row_n,
    input  col_n,
    input  tecla,
    input  ready,
    input  key_down
  );
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, debounces press and release,
// and emits one key code with a fixed-width ready pulse per physical press.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   kp    : keypad_encoder_if.master (row_n in; col_n, tecla, ready, key_down out)
module keypad_encoder #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int READY_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              reset,
  keypad_encoder_if.master  kp
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RC_W  = $clog2(READY_CYCLES + 1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE_P = 2'd1,
    EMIT       = 2'd2,
    WAIT_REL   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        rs_meta_q, rs_q;
  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [DB_W-1:0]   dbc_q, dbc_d;
  logic [RC_W-1:0]   pc_q, pc_d;
  logic [3:0]        tecla_q, tecla_d;
  logic              ready_q, ready_d;
  logic              kd_q, kd_d;
  logic              hit;
  logic [1:0]        hit_row;
  logic [3:0]        code;

  // Row synchronizer and free-running scan prescaler.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_meta_q <= '1;
      rs_q      <= '1;
      div_q     <= '0;
    end else begin
      rs_meta_q <= kp.row_n;
      rs_q      <= rs_meta_q;
      div_q     <= tick ? '0 : div_q + 1'b1;
    end
  end

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Lowest-index low row wins among simultaneous keys in one column.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    if      (!rs_q[0]) hit_row = 2'd0;
    else if (!rs_q[1]) hit_row = 2'd1;
    else if (!rs_q[2]) hit_row = 2'd2;
    else if (!rs_q[3]) hit_row = 2'd3;
    else               hit     = 1'b0;
  end

  always_comb begin
    code = 4'b1111;
    case ({row_q, col_q})
      4'b00_00: code = 4'b0001;
      4'b00_01: code = 4'b0010;
      4'b00_10: code = 4'b0011;
      4'b00_11: code = 4'b1010;
      4'b01_00: code = 4'b0100;
      4'b01_01: code = 4'b0101;
      4'b01_10: code = 4'b0110;
      4'b01_11: code = 4'b1011;
      4'b10_00: code = 4'b0111;
      4'b10_01: code = 4'b1000;
      4'b10_10: code = 4'b1001;
      4'b10_11: code = 4'b1100;
      4'b11_00: code = 4'b1110;
      4'b11_01: code = 4'b0000;
      4'b11_10: code = 4'b1111;
      4'b11_11: code = 4'b1101;
      default:  code = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      dbc_q   <= '0;
      pc_q    <= '0;
      tecla_q <= '1;
      ready_q <= 1'b0;
      kd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dbc_q   <= dbc_d;
      pc_q    <= pc_d;
      tecla_q <= tecla_d;
      ready_q <= ready_d;
      kd_q    <= kd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dbc_d   = dbc_q;
    pc_d    = pc_q;
    tecla_d = tecla_q;
    ready_d = ready_q;
    kd_d    = kd_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (hit) begin
            row_d   = hit_row;
            dbc_d   = '0;
            state_d = DEBOUNCE_P;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE_P: begin
        if (tick) begin
          if (hit && (hit_row == row_q)) begin
            // The pulse is launched on the confirming edge so that ready is
            // high for every clock spent in EMIT.
            if (dbc_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
              dbc_d   = '0;
              pc_d    = '0;
              tecla_d = code;
              ready_d = 1'b1;
              kd_d    = 1'b1;
              state_d = EMIT;
            end else begin
              dbc_d = dbc_q + 1'b1;
            end
          end else begin
            state_d = SCAN;
          end
        end
      end
      EMIT: begin
        if (pc_q == RC_W'(READY_CYCLES - 1)) begin
          ready_d = 1'b0;
          dbc_d   = '0;
          state_d = WAIT_REL;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (tick) begin
          if (!hit) begin
            if (dbc_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
              kd_d    = 1'b0;
              dbc_d   = '0;
              state_d = SCAN;
            end else begin
              dbc_d = dbc_q + 1'b1;
            end
          end else begin
            dbc_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign kp.col_n    = ~(4'b0001 << col_q);
  assign kp.tecla    = tecla_q;
  assign kp.ready    = ready_q;
  assign kp.key_down = kd_q;

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Scans a 4x4 active-low matrix keypad and debounces key presses and releases.
- Encodes each confirmed press into the 4-bit key code consumed by the calculator control FSM, then emits a `ready` pulse; the FSM samples `tecla` on the falling edge of `ready`.
- Sits between the board keypad pins and the calculator FSM's `tecla`/`ready` inputs.
- Exactly one code and one pulse per physical press; auto-repeat is not supported.

Parameters:
- CLK_DIV, 50000, clocks per scan tick; legal range >= 4.
- DEBOUNCE_TICKS, 4, consecutive stable ticks required to confirm a press and to confirm a release; legal range >= 1.
- READY_CYCLES, 8, width of the `ready` high pulse in clocks; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  reset, synchronous, active-low.
- row_n  input  4  keypad rows, active low, externally pulled up, asynchronous to clk.
- col_n  output  4  keypad column drive; exactly one bit low (the column being driven).
- tecla  output  4  encoded key code; held until the next emission.
- ready  output  1  high for READY_CYCLES clocks per confirmed press.
- key_down  output  1  high from confirmed press until confirmed release.

Behaviour:
- Reset (reset==0 at a rising edge), effective at that edge from any state:
  - col_n=4'b1110, tecla=4'b1111 (no-op code), ready=0, key_down=0.
  - Prescaler, debounce counter and pulse counter cleared; state=SCAN.
  - Reset mid-pulse truncates `ready` to 0 at that edge.
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- Prescaler:
  - Counts 0..CLK_DIV-1; `tick` is a 1-clock strobe when count==CLK_DIV-1, then the count wraps to 0.
  - Free-running in every state.
- Key code map, row r / col c:
  - r0: 1,2,3,A = 0001, 0010, 0011, 1010 (sum)
  - r1: 4,5,6,B = 0100, 0101, 0110, 1011 (subtract)
  - r2: 7,8,9,C = 0111, 1000, 1001, 1100 (store)
  - r3: *,0,#,D = 1110 (enter), 0000, 1111 (no-op), 1101 (load)
- FSM:
  - SCAN: on tick, if rs != 4'hF, latch the column and the lowest-index low row, clear the debounce counter, go to DEBOUNCE_P. Otherwise rotate col_n to the next column (1110→1101→1011→0111→1110). The column therefore settles for one full tick before it is sampled.
  - DEBOUNCE_P: col_n frozen. On tick:
    - If the lowest low row of rs equals the latched row, increment the counter.
    - Otherwise (rs all high, or a different row) return to SCAN with the column unchanged.
    - When the counter reaches DEBOUNCE_TICKS, go to EMIT.
  - EMIT, first clock: tecla<=code, ready<=1, key_down<=1. ready stays high for exactly READY_CYCLES clocks, then ready<=0 and state goes to WAIT_REL. tecla does not change while ready is high or after it falls.
  - WAIT_REL: col_n frozen. On tick:
    - If rs==4'hF, increment the counter; otherwise clear it.
    - When the counter reaches DEBOUNCE_TICKS, key_down<=0, clear the counter, go to SCAN with the column unchanged.
- Simultaneous keys:
  - Same column: the lowest row index wins.
  - Different columns: the first column reached by the scan wins.
  - Keys pressed while in WAIT_REL are ignored until all rows of the latched column are released. Keys in other columns are not visible in WAIT_REL and produce no code.
- Latency from stable press to ready rise: at most (4+DEBOUNCE_TICKS+1)*CLK_DIV + 3 clocks.

Test Plan:
Bench parameters: CLK_DIV=4, DEBOUNCE_TICKS=3, READY_CYCLES=2.
- Reset: hold reset=0 for 3 clocks with row_n=F → col_n=1110, tecla=1111, ready=0, key_down=0; col_n rotates every 4 clocks after release.
- Clean press row1/col2 ('6') → exactly one ready pulse 2 clocks wide with tecla=0110; key_down=1 until 3 release ticks after rows return to F; no second pulse.
- Bounce: row0/col3 low for 1 tick, high for 1 tick, then stable → no pulse during the bounce; one pulse with tecla=1010 after 3 stable ticks.
- Two rows of col1 pressed (row1 and row3) → tecla=0101, single pulse.
- Press '*', release, press '0' → two pulses, tecla=1110 then 0000; tecla holds 1110 between them.
- Reset asserted during the ready-high cycle → ready=0 at that edge, state returns to SCAN, tecla=1111.
